// File: rtl/burst_collector.sv
// Read-side sink: requests 4-word memory bursts, captures the read data that
// trails each cen by one cycle, and hands the packed burst downstream.
module burst_collector #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req,
    input  logic            cen,
    input  logic            start,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   rdata,
    output logic            pkt_valid,
    input  logic            pkt_ready,
    output logic [4*DW-1:0] pkt_data,
    output logic [AW-1:0]   pkt_addr,
    output logic [7:0]      pkt_cnt,
    output logic            err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] state;
    logic       cen_d;
    logic [1:0] idx_d;
    logic [1:0] slot;
    logic       capture;

    // Captures only land while filling, so a stray read issued during HOLD
    // cannot disturb the packet waiting on the consumer.
    assign capture = cen_d && (state == FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            pkt_addr  <= '0;
            pkt_cnt   <= 8'd0;
            err       <= 1'b0;
            cen_d     <= 1'b0;
            idx_d     <= 2'd0;
            slot      <= 2'd0;
        end else begin
            cen_d <= cen;
            idx_d <= addr[1:0];

            if (capture)
                pkt_data[idx_d*DW +: DW] <= rdata;

            if ((capture && (idx_d != slot)) ||
                (cen && (state == HOLD)) ||
                (start && (state != FILL)))
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (cen) begin
                        req      <= 1'b0;
                        pkt_addr <= {addr[AW-1:2], 2'b00};
                        slot     <= 2'd0;
                        state    <= FILL;
                    end else begin
                        req <= 1'b1;
                    end
                end
                FILL: begin
                    req <= 1'b0;
                    if (capture) begin
                        slot <= 2'(slot + 2'd1);
                        if (slot == 2'd3) begin
                            pkt_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        pkt_valid <= 1'b0;
                        pkt_cnt   <= pkt_cnt + 8'd1;
                        req       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
